// File: rtl/apb_master_bridge_pkg.sv
// Shared types and widths for the APB master bridge.
// The state enum and the address decoder are reused by the AXI4-Lite bridge.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    ERR
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// CPU load/store side and APB3 side of the bridge, bundled.
// The bridge takes the master view; the peripheral fabric takes the slave view.
interface apb_master_bridge_if #(
  parameter int NUM_SLAVES = 4
);
  import apb_pkg::*;

  logic                             transfer;
  logic                             write;
  logic [APB_ADDR_W-1:0]            addr;
  logic [APB_DATA_W-1:0]            wdata;
  logic [APB_DATA_W-1:0]            rdata;
  logic                             ready;
  logic                             err;

  logic [APB_ADDR_W-1:0]            PADDR;
  logic [APB_DATA_W-1:0]            PWDATA;
  logic                             PWRITE;
  logic                             PENABLE;
  logic [NUM_SLAVES-1:0]            PSEL;
  logic [APB_DATA_W*NUM_SLAVES-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]            PREADY;

  modport master (
    input  transfer,
    input  write,
    input  addr,
    input  wdata,
    output rdata,
    output ready,
    output err,
    output PADDR,
    output PWDATA,
    output PWRITE,
    output PENABLE,
    output PSEL,
    input  PRDATA,
    input  PREADY
  );

  modport slave (
    output transfer,
    output write,
    output addr,
    output wdata,
    input  rdata,
    input  ready,
    input  err,
    input  PADDR,
    input  PWDATA,
    input  PWRITE,
    input  PENABLE,
    input  PSEL,
    output PRDATA,
    output PREADY
  );

endinterface

// File: rtl/apb_master_bridge_addr_decoder.sv
// Combinational window decoder: byte address -> one-hot slave select + hit.
// Addresses below the base never wrap around into a slave window.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int                    NUM_SLAVES = 4,
  parameter logic [APB_ADDR_W-1:0] ADDR_BASE  = 32'h1000_0000,
  parameter logic [APB_ADDR_W-1:0] SLAVE_SPAN = 32'h0000_1000
) (
  input  logic [APB_ADDR_W-1:0] addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  hit
);

  logic [APB_ADDR_W-1:0] offset;
  logic [APB_ADDR_W-1:0] slot;

  always_comb begin
    offset = addr - ADDR_BASE;
    slot   = offset / SLAVE_SPAN;
    hit    = (addr >= ADDR_BASE) &&
             (slot < APB_ADDR_W'(NUM_SLAVES));
    sel    = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = hit && (slot == APB_ADDR_W'(i));
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// CPU load/store bus to APB3 master: decode, SETUP/ACCESS sequencing,
// wait-state timeout and read-data return with a one-cycle ready pulse.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int                    NUM_SLAVES = 4,
  parameter logic [APB_ADDR_W-1:0] ADDR_BASE  = 32'h1000_0000,
  parameter logic [APB_ADDR_W-1:0] SLAVE_SPAN = 32'h0000_1000,
  parameter int                    TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst,
  apb_master_bridge_if.master bus
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  apb_state_e            state;
  logic [APB_ADDR_W-1:0] paddr_q;
  logic [APB_DATA_W-1:0] pwdata_q;
  logic                  pwrite_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [CW-1:0]         cnt_q;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_hit;
  logic                  slave_ready;
  logic [APB_DATA_W-1:0] slave_rdata;
  logic                  expired;

  logic [NUM_SLAVES-1:0] psel;
  logic                  penable;
  logic                  ready;
  logic                  err;
  logic [APB_DATA_W-1:0] rdata;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_BASE  (ADDR_BASE),
    .SLAVE_SPAN (SLAVE_SPAN)
  ) u_dec (
    .addr (bus.addr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  // One-hot latched select drives the PREADY/PRDATA return mux
  always_comb begin
    slave_ready = |(bus.PREADY & sel_q);
    slave_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        slave_rdata = slave_rdata |
          bus.PRDATA[APB_DATA_W*i +: APB_DATA_W];
      end
    end
  end

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  // PREADY is checked before the timeout so a late ready still succeeds
  always_comb begin
    psel    = '0;
    penable = 1'b0;
    ready   = 1'b0;
    err     = 1'b0;
    rdata   = '0;
    unique case (state)
      IDLE: ;
      SETUP: begin
        psel = sel_q;
      end
      ACCESS: begin
        psel    = sel_q;
        penable = 1'b1;
        if (slave_ready) begin
          ready = 1'b1;
          rdata = pwrite_q ? '0 : slave_rdata;
        end else if (expired) begin
          ready = 1'b1;
          err   = 1'b1;
        end
      end
      ERR: begin
        ready = 1'b1;
        err   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      sel_q    <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.transfer) begin
            paddr_q  <= bus.addr;
            pwdata_q <= bus.wdata;
            pwrite_q <= bus.write;
            sel_q    <= dec_sel;
            state    <= dec_hit ? SETUP : ERR;
          end
        end
        SETUP: begin
          cnt_q <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          if (slave_ready || expired) begin
            state <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ERR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PSEL    = psel;
  assign bus.PENABLE = penable;
  assign bus.ready   = ready;
  assign bus.err     = err;
  assign bus.rdata   = rdata;

endmodule
